fetch_stage: RTL

// - IF stage and IF/ID pipeline register of the 5-stage RISCV core; feeds ID_instr/ID_pc into decode.
// - Consumes stall_op from Stall_Control (holds IF/ID, buffers in-flight fetch); branch redirect from EX flushes.
// - Single outstanding req/gnt/rvalid instruction-memory transaction; 1-entry hold buffer absorbs data returned during stall.
//

---
 rtl/fetch_stage.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage with a single-outstanding req/gnt/rvalid fetch, a 1-entry stall buffer and the IF/ID register.
// Define FETCH_PERF_CNT_EN to add stall/flush performance counter outputs.
module fetch_stage #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_ip,
  input  logic        branch_taken_ip,
  input  logic [31:0] branch_target_ip,
  output logic        imem_req_op,
  output logic [31:0] imem_addr_op,
  input  logic        imem_gnt_ip,
  input  logic        imem_rvalid_ip,
  input  logic [31:0] imem_rdata_ip,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_stall_cnt_op,
  output logic [31:0] perf_flush_cnt_op,
`endif
  output logic        ID_valid_op,
  output logic [31:0] ID_instr_op,
  output logic [31:0] ID_pc_op
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        started_q, started_d;

  logic        load;
  logic [31:0] load_instr;
  logic [31:0] load_pc;

  // The first request is held off until one cycle after reset release.
  assign started_d    = 1'b1;
  assign imem_req_op  = (state_q == FETCH) && started_q && !branch_taken_ip;
  assign imem_addr_op = pc_q;
  assign ID_valid_op  = id_valid_q;
  assign ID_instr_op  = id_instr_q;
  assign ID_pc_op     = id_pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    drop_d      = drop_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    load        = 1'b0;
    load_instr  = NOP_INSTR;
    load_pc     = id_pc_q;

    if (branch_taken_ip) begin
      // A redirect outranks stall: any in-flight or buffered fetch is stale.
      pc_d = branch_target_ip & ~32'd3;
      unique case (state_q)
        FETCH: state_d = FETCH;
        WAIT: begin
          if (imem_rvalid_ip) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            drop_d = 1'b1;
          end
        end
        HOLD:    state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_req_op && imem_gnt_ip) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_ip) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = FETCH;
            end else if (!stall_ip) begin
              load       = 1'b1;
              load_instr = imem_rdata_ip;
              load_pc    = req_pc_q;
              state_d    = FETCH;
            end else begin
              buf_instr_d = imem_rdata_ip;
              buf_pc_d    = req_pc_q;
              state_d     = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_ip) begin
            load       = 1'b1;
            load_instr = buf_instr_q;
            load_pc    = buf_pc_q;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // IF/ID register: a redirect always bubbles; otherwise load, bubble, or hold under stall.
  always_comb begin
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    if (branch_taken_ip) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end else if (load) begin
      id_valid_d = 1'b1;
      id_instr_d = load_instr;
      id_pc_d    = load_pc;
    end else if (!stall_ip) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= BOOT_ADDR;
      req_pc_q    <= 32'd0;
      drop_q      <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= 32'd0;
      id_valid_q  <= 1'b0;
      id_instr_q  <= NOP_INSTR;
      id_pc_q     <= 32'd0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      drop_q      <= drop_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      started_q   <= started_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    perf_flush_cnt_d = perf_flush_cnt_q;
    if (stall_ip && id_valid_q) perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    if (branch_taken_ip)        perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt_q <= 32'd0;
      perf_flush_cnt_q <= 32'd0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_stall_cnt_op = perf_stall_cnt_q;
  assign perf_flush_cnt_op = perf_flush_cnt_q;
`endif

endmodule
